// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and FLAGS bit positions
// shared by the control sequencer and its register file.
package cpu_pkg;

   localparam logic [3:0] OP_MOV  = 4'b0000;
   localparam logic [3:0] OP_INC  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_LDI  = 4'b0011;
   localparam logic [3:0] OP_JMP  = 4'b0100;
   localparam logic [3:0] OP_SUB  = 4'b0101;
   localparam logic [3:0] OP_DEC  = 4'b0110;
   localparam logic [3:0] OP_PASS = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_JZ   = 4'b1001;
   localparam logic [3:0] OP_OR   = 4'b1010;
   localparam logic [3:0] OP_JC   = 4'b1011;
   localparam logic [3:0] OP_XOR  = 4'b1100;
   localparam logic [3:0] OP_JN   = 4'b1101;
   localparam logic [3:0] OP_NOT  = 4'b1110;
   localparam logic [3:0] OP_HLT  = 4'b1111;

   localparam int FZ = 3;
   localparam int FC = 2;
   localparam int FS = 1;
   localparam int FV = 0;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_WB,
      S_HALT
   } state_e;

   // ALU ops reuse their opcode as the SSEL value
   function automatic logic is_alu_op(input logic [3:0] op);
      case (op)
         OP_MOV, OP_INC, OP_ADD, OP_SUB, OP_DEC,
         OP_PASS, OP_AND, OP_OR, OP_XOR, OP_NOT:
            is_alu_op = 1'b1;
         default:
            is_alu_op = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/cpu_ctrl_regfile.sv
// cpu_ctrl_regfile: 4x8 register file, two async read ports,
// one sync write port, sync active-high reset clears all entries.
// Ports: clk_i, rst_i, we_i/waddr_i/wdata_i (write),
//        raddr_a_i/rdata_a_o, raddr_b_i/rdata_b_o (reads).
module cpu_ctrl_regfile (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       we_i,
   input  logic [1:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [1:0] raddr_a_i,
   input  logic [1:0] raddr_b_i,
   output logic [7:0] rdata_a_o,
   output logic [7:0] rdata_b_o
);

   logic [7:0] rf_q [4];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < 4; i++) begin
            rf_q[i] <= '0;
         end
      end else if (we_i) begin
         rf_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_a_o = rf_q[raddr_a_i];
   assign rdata_b_o = rf_q[raddr_b_i];

endmodule

// File: rtl/cpu_ctrl_seq.sv
// cpu_ctrl_seq: multi-cycle FETCH/DECODE/EXEC/WB sequencer that
// drives an external 8-bit ALU and takes jumps on latched flags.
// Ports: clk_i, rst_i (sync, active high); ireq_o/iaddr_o/
//   idata_i/ivalid_i fetch; alu_a_o/alu_b_o/ssel_o to ALU;
//   alu_f_i, alu_z_i/c_i/s_i/v_i from ALU; flags_o {Z,C,S,V};
//   halted_o; trap_o overflow-trap pulse.
// Macro CPU_CTRL_VTRAP_EN enables the overflow trap to TRAP_VEC.
module cpu_ctrl_seq
   import cpu_pkg::*;
#(
   parameter int         PC_W     = 8,
   parameter logic [7:0] TRAP_VEC = 8'hF0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   output logic            ireq_o,
   output logic [PC_W-1:0] iaddr_o,
   input  logic [15:0]     idata_i,
   input  logic            ivalid_i,
   output logic [7:0]      alu_a_o,
   output logic [7:0]      alu_b_o,
   output logic [3:0]      ssel_o,
   input  logic [7:0]      alu_f_i,
   input  logic            alu_z_i,
   input  logic            alu_c_i,
   input  logic            alu_s_i,
   input  logic            alu_v_i,
   output logic [3:0]      flags_o,
   output logic            halted_o,
   output logic            trap_o
);

   state_e          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [15:0]     ir_q, ir_d;
   logic [3:0]      flags_q, flags_d;
   logic [3:0]      ssel_q, ssel_d;
   logic [7:0]      a_q, a_d;
   logic [7:0]      b_q, b_d;
   logic [11:0]     res_q, res_d;
   logic            ireq_q, ireq_d;

   logic [3:0] op;
   logic [1:0] rd, rs;
   logic [7:0] imm;
   logic [7:0] rf_a, rf_b;
   logic       rf_we;
   logic [7:0] rf_wdata;
   logic       take_jump;
   logic       trap_hit;

   assign op  = ir_q[15:12];
   assign rd  = ir_q[11:10];
   assign rs  = ir_q[9:8];
   assign imm = ir_q[7:0];

   cpu_ctrl_regfile u_rf (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .we_i      (rf_we),
      .waddr_i   (rd),
      .wdata_i   (rf_wdata),
      .raddr_a_i (rd),
      .raddr_b_i (rs),
      .rdata_a_o (rf_a),
      .rdata_b_o (rf_b)
   );

   // conditions look only at the latched flags
   always_comb begin
      take_jump = 1'b0;
      case (op)
         OP_JMP:  take_jump = 1'b1;
         OP_JZ:   take_jump = flags_q[FZ];
         OP_JC:   take_jump = flags_q[FC];
         OP_JN:   take_jump = flags_q[FS];
         default: take_jump = 1'b0;
      endcase
   end

`ifdef CPU_CTRL_VTRAP_EN
   assign trap_hit = (state_q == S_WB) && res_q[FV] &&
                     (op == OP_ADD || op == OP_SUB ||
                      op == OP_INC || op == OP_DEC);
`else
   assign trap_hit = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      flags_d  = flags_q;
      ssel_d   = ssel_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      rf_we    = 1'b0;
      rf_wdata = res_q[11:4];
      case (state_q)
         S_FETCH: begin
            if (ireq_q && ivalid_i) begin
               ir_d    = idata_i;
               pc_d    = pc_q + 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d     = rf_a;
            b_d     = rf_b;
            ssel_d  = is_alu_op(op) ? op : 4'b0000;
            state_d = (op == OP_HLT) ? S_HALT : S_EXEC;
         end
         S_EXEC: begin
            res_d   = {alu_f_i, alu_z_i, alu_c_i,
                       alu_s_i, alu_v_i};
            state_d = S_WB;
         end
         S_WB: begin
            state_d = S_FETCH;
            unique case (1'b1)
               is_alu_op(op): begin
                  rf_we   = 1'b1;
                  flags_d = res_q[3:0];
               end
               (op == OP_LDI): begin
                  rf_we    = 1'b1;
                  rf_wdata = imm;
               end
               take_jump: pc_d = imm[PC_W-1:0];
               default: ;
            endcase
            // result and flags still commit on a trap
            if (trap_hit) pc_d = TRAP_VEC[PC_W-1:0];
         end
         S_HALT: ;
         default: state_d = S_FETCH;
      endcase
      ireq_d = (state_d == S_FETCH);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         flags_q <= '0;
         ssel_q  <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         ireq_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flags_q <= flags_d;
         ssel_q  <= ssel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         ireq_q  <= ireq_d;
      end
   end

   assign ireq_o   = ireq_q;
   assign iaddr_o  = pc_q;
   assign alu_a_o  = a_q;
   assign alu_b_o  = b_q;
   assign ssel_o   = ssel_q;
   assign flags_o  = flags_q;
   assign halted_o = (state_q == S_HALT);
   assign trap_o   = trap_hit;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb_cpu_ctrl_seq: instruction-level model plus a per-cycle
// compare process for cpu_ctrl_seq with a behavioural ALU.
module tb_cpu_ctrl_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        ireq;
   logic [7:0]  iaddr;
   logic [15:0] idata;
   logic        ivalid;
   logic [7:0]  alu_a, alu_b, alu_f;
   logic [3:0]  ssel;
   logic        alu_z, alu_c, alu_s, alu_v;
   logic [3:0]  flags;
   logic        halted, trap;

   always #5 clk = ~clk;

   cpu_ctrl_seq dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .ireq_o   (ireq),
      .iaddr_o  (iaddr),
      .idata_i  (idata),
      .ivalid_i (ivalid),
      .alu_a_o  (alu_a),
      .alu_b_o  (alu_b),
      .ssel_o   (ssel),
      .alu_f_i  (alu_f),
      .alu_z_i  (alu_z),
      .alu_c_i  (alu_c),
      .alu_s_i  (alu_s),
      .alu_v_i  (alu_v),
      .flags_o  (flags),
      .halted_o (halted),
      .trap_o   (trap)
   );

   // external ALU: returns {F, Z, C, S, V}
   function automatic logic [11:0] alu_fn(
      input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] r;
      logic       c, v;
      r = '0; c = 1'b0; v = 1'b0;
      case (op)
         4'd0:  r = {1'b0, b};
         4'd1:  begin r = {1'b0, a} + 9'd1; c = r[8]; v = (a == 8'h7F); end
         4'd2:  begin
            r = {1'b0, a} + {1'b0, b}; c = r[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'd5:  begin
            r = {1'b0, a} - {1'b0, b}; c = r[8];
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'd6:  begin r = {1'b0, a} - 9'd1; c = r[8]; v = (a == 8'h80); end
         4'd7:  r = {1'b0, a};
         4'd8:  r = {1'b0, a & b};
         4'd10: r = {1'b0, a | b};
         4'd12: r = {1'b0, a ^ b};
         4'd14: r = {1'b0, ~a};
         default: r = '0;
      endcase
      return {r[7:0], (r[7:0] == 8'h00), c, r[7], v};
   endfunction

   always_comb begin
      {alu_f, alu_z, alu_c, alu_s, alu_v} = alu_fn(ssel, alu_a, alu_b);
   end

   // architectural model
   logic [15:0] mem [256];
   logic [7:0]  m_r [4];
   logic [7:0]  m_pc;
   logic [3:0]  m_flags;

   function automatic bit m_is_alu(input logic [3:0] op);
      return op inside {4'd0, 4'd1, 4'd2, 4'd5, 4'd6,
                        4'd7, 4'd8, 4'd10, 4'd12, 4'd14};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
      m_pc    = 8'h00;
      m_flags = 4'h0;
   endtask

   task automatic m_step(input logic [15:0] ins, output bit tr);
      logic [3:0]  op;
      logic [1:0]  rd, rs;
      logic [7:0]  imm;
      logic [11:0] res;
      op = ins[15:12]; rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
      tr = 1'b0;
      m_pc = m_pc + 8'd1;
      if (m_is_alu(op)) begin
         res = alu_fn(op, m_r[rd], m_r[rs]);
         m_r[rd] = res[11:4];
         m_flags = res[3:0];
`ifdef CPU_CTRL_VTRAP_EN
         if ((op inside {4'd1, 4'd2, 4'd5, 4'd6}) && res[0]) begin
            m_pc = 8'hF0;
            tr   = 1'b1;
         end
`endif
      end else begin
         case (op)
            4'd3:  m_r[rd] = imm;
            4'd4:  m_pc = imm;
            4'd9:  if (m_flags[3]) m_pc = imm;
            4'd11: if (m_flags[2]) m_pc = imm;
            4'd13: if (m_flags[1]) m_pc = imm;
            default: ;
         endcase
      end
   endtask

   // expectations for the current cycle, checked at negedge
   int   checks = 0;
   int   errors = 0;
   bit   chk_en = 1'b0;
   bit   chk_alu;
   logic exp_ireq, exp_halted, exp_trap;
   logic [7:0] exp_iaddr, exp_a, exp_b;
   logic [3:0] exp_flags, exp_ssel;

   task automatic chk(input string nm, input logic [15:0] act,
                      input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t",
                  nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("ireq",   {15'd0, ireq},   {15'd0, exp_ireq});
         chk("iaddr",  {8'd0, iaddr},   {8'd0, exp_iaddr});
         chk("halted", {15'd0, halted}, {15'd0, exp_halted});
         chk("flags",  {12'd0, flags},  {12'd0, exp_flags});
         chk("trap",   {15'd0, trap},   {15'd0, exp_trap});
         if (chk_alu) begin
            chk("alu_a", {8'd0, alu_a}, {8'd0, exp_a});
            chk("alu_b", {8'd0, alu_b}, {8'd0, exp_b});
            chk("ssel",  {12'd0, ssel}, {12'd0, exp_ssel});
         end
      end
   end

   task automatic win();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reset_exp();
      exp_ireq = 1'b0; exp_iaddr = 8'h00; exp_halted = 1'b0;
      exp_flags = 4'h0; exp_trap = 1'b0;
      chk_alu = 1'b1; exp_a = 8'h00; exp_b = 8'h00; exp_ssel = 4'h0;
   endtask

   task automatic do_reset();
      rst = 1'b1; ivalid = 1'b0;
      win();
      set_reset_exp();
      chk_en = 1'b1;
      rst = 1'b0;
      m_reset();
   endtask

   task automatic do_instr(input int stalls, input bit abort);
      logic [15:0] ins;
      logic [7:0]  pc1, ea, eb;
      logic [3:0]  es, oflags;
      bit          etrap;
      for (int s = 0; s <= stalls; s++) begin
         win();
         exp_ireq = 1'b1; exp_iaddr = m_pc; exp_halted = 1'b0;
         exp_flags = m_flags; exp_trap = 1'b0; chk_alu = 1'b0;
         ivalid = (s == stalls);
         idata  = (s == stalls) ? mem[m_pc] : 16'hF000;
      end
      ins    = mem[m_pc];
      pc1    = m_pc + 8'd1;
      ea     = m_r[ins[11:10]];
      eb     = m_r[ins[9:8]];
      es     = m_is_alu(ins[15:12]) ? ins[15:12] : 4'h0;
      oflags = m_flags;
      m_step(ins, etrap);
      win();
      exp_ireq = 1'b0; exp_iaddr = pc1; exp_flags = oflags;
      ivalid = 1'b1; idata = 16'hF000;
      if (ins[15:12] == 4'hF) begin
         for (int i = 0; i < 6; i++) begin
            win();
            exp_halted = 1'b1; exp_ireq = 1'b0;
            ivalid = i[0]; idata = mem[0];
         end
         return;
      end
      win();
      chk_alu = 1'b1; exp_a = ea; exp_b = eb; exp_ssel = es;
      ivalid = 1'b0;
      if (abort) begin
         rst = 1'b1;
         win();
         set_reset_exp();
         rst = 1'b0;
         m_reset();
         return;
      end
      win();
      exp_trap = etrap;
   endtask

   initial begin
      rst = 1'b1; ivalid = 1'b0; idata = 16'h0000;
      for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
      mem[8'h00] = 16'h347F;  // LDI R1,7F
      mem[8'h01] = 16'h3801;  // LDI R2,01
      mem[8'h02] = 16'h2600;  // ADD R1,R2
      mem[8'h03] = 16'h3001;  // LDI R0,1
      mem[8'h04] = 16'h6000;  // DEC R0
      mem[8'h05] = 16'h9020;  // JZ 20
      mem[8'h20] = 16'h3002;  // LDI R0,2
      mem[8'h21] = 16'h6000;  // DEC R0
      mem[8'h22] = 16'h9020;  // JZ 20 (not taken)
      mem[8'h23] = 16'h40FF;  // JMP FF
      mem[8'hFF] = 16'h3C7F;  // LDI R3,7F

      do_reset();
      for (int i = 0; i < 3; i++) do_instr(0, 1'b0);
      chk("model R1 after ADD", {8'd0, m_r[1]}, 16'h0080);
      chk("model FLAGS after ADD", {12'd0, m_flags}, 16'h0003);

      for (int i = 0; i < 3; i++) do_instr(0, 1'b0);
      chk("model PC JZ taken", {8'd0, m_pc}, 16'h0020);

      for (int i = 0; i < 3; i++) do_instr(0, 1'b0);
      chk("model PC JZ not taken", {8'd0, m_pc}, 16'h0023);

      do_instr(0, 1'b0);
      chk("model PC JMP", {8'd0, m_pc}, 16'h00FF);
      do_instr(3, 1'b0);
      chk("model PC wrap", {8'd0, m_pc}, 16'h0000);

      // reset in the EXEC cycle of ADD
      do_instr(0, 1'b0);
      do_instr(0, 1'b0);
      do_instr(0, 1'b1);

      mem[8'h00] = 16'h2600;  // ADD R1,R2 on cleared regs
      mem[8'h01] = 16'h3C7F;  // LDI R3,7F
      mem[8'h02] = 16'h1C00;  // INC R3
      mem[8'h03] = 16'hF000;  // HLT
      mem[8'hF0] = 16'hF000;  // HLT
      for (int i = 0; i < 3; i++) do_instr(0, 1'b0);
`ifdef CPU_CTRL_VTRAP_EN
      chk("model PC trap", {8'd0, m_pc}, 16'h00F0);
`else
      chk("model PC no trap", {8'd0, m_pc}, 16'h0003);
`endif
      chk("model FLAGS after INC", {12'd0, m_flags}, 16'h0003);

      do_instr(1, 1'b0);
      do_reset();
      do_instr(0, 1'b0);
      win();
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
